// File: rtl/desp_multiciclo.sv
// Multi-cycle SLL/SRL/SRA shifter, STEP bits per clock, with a start/busy/done handshake.
// Optional macro DESP_ROTATE_EN turns op=01 into ROTR; without it op=01 behaves as SRL.
//
//   state | meaning
//   IDLE  | waiting for start; y holds the last result
//   SHIFT | shifting y by min(rem, STEP) each edge; busy=1
//   DONE  | one-cycle result-valid pulse; a new start is accepted here too
module desp_multiciclo #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   y
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(STEP);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   y_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic [SHAMT_W:0]   step_amt;
  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   shifted;

`ifdef DESP_ROTATE_EN
  localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W+1)'(WIDTH);
  logic [SHAMT_W:0] rot_amt;
  assign rot_amt = WIDTH_C - step_amt;
`endif

  // Extra bit on step_amt so STEP=WIDTH is representable.
  assign step_amt  = ({1'b0, rem_q} < STEP_C) ? {1'b0, rem_q} : STEP_C;
  assign fill_mask = ~({WIDTH{1'b1}} >> step_amt);

  always_comb begin
    shifted = y >> step_amt;
    case (op_q)
      2'b00: shifted = y << step_amt;
      2'b11: shifted = (y >> step_amt) | (sign_q ? fill_mask : '0);
`ifdef DESP_ROTATE_EN
      2'b01: shifted = (y >> step_amt) | (y << rot_amt);
`endif
      default: shifted = y >> step_amt;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y;
    rem_d   = rem_q;
    op_d    = op_q;
    sign_d  = sign_q;
    case (state_q)
      S_SHIFT: begin
        y_d   = shifted;
        rem_d = rem_q - step_amt[SHAMT_W-1:0];
        if ({1'b0, rem_q} == step_amt) state_d = S_DONE;
      end
      default: begin
        if (start) begin
          y_d     = a;
          rem_d   = shamt;
          op_d    = op;
          sign_d  = a[WIDTH-1];
          state_d = (shamt != '0) ? S_SHIFT : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y       <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y       <= y_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule
